z_depth_test: RTL and testbench
===============================

// Module: z_depth_test
// PURPOSE
//  Depth-test stage downstream of z_interpolation: consumes the interpolated (x,y,z) pixel stream
//  for one 32x32 tile, compares each z against an on-chip tile depth buffer, writes back passing z,
//  and emits a per-pixel pass flag to the pixel writer. Owns tile depth-buffer clearing.
// PARAMETERS
//  Z_W        27   depth width, matches z_interpolation output
//  TILE_LOG2  5    tile edge = 2**TILE_LOG2 (32); depth RAM depth = 1024
//  LEQUAL     0    0: pass if z < stored; 1: pass if z <= stored (unsigned compare)
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous, active-high reset
//  clear_start  in   1          request tile depth clear to all-ones (far plane)
//  clear_busy   out  1          high while clearing or draining before clear
//  in_valid     in   1          pixel valid
//  in_ready     out  1          pixel accepted when in_valid && in_ready
//  in_x         in   TILE_LOG2  pixel x in tile
//  in_y         in   TILE_LOG2  pixel y in tile
//  in_z         in   Z_W        interpolated depth
//  in_last      in   1          last pixel of tile
//  out_valid    out  1          result valid (no backpressure; downstream must accept)
//  out_x/out_y  out  TILE_LOG2  echoed coordinates
//  out_z        out  Z_W        echoed depth
//  out_pass     out  1          1 = depth test passed, buffer updated
//  out_last     out  1          echoed in_last
//  tile_done    out  1          1-cycle pulse with out_valid && out_last
// BEHAVIOUR
//  - States: CLEAR, RUN, DRAIN. rst -> CLEAR, clear counter = 0, pipeline valids = 0.
//  - Reset values: in_ready=0, clear_busy=1, out_valid=0, out_pass=0, out_last=0, tile_done=0,
//    out_x/out_y/out_z=0. RAM contents not reset; reset always re-runs CLEAR.
//  - CLEAR: write all-ones to address cnt, cnt++ each cycle; 1024 cycles; at cnt==1023 -> RUN.
//    clear_busy=1, in_ready=0. clear_start ignored in CLEAR. rst mid-clear restarts at cnt=0.
//  - RUN: in_ready = !clear_start. clear_start=1 -> DRAIN; a pixel with in_valid the same cycle
//    is NOT accepted (clear wins).
//  - DRAIN: in_ready=0, clear_busy=1; wait until both pipeline stages empty, then -> CLEAR.
//  - Pipeline (address = {y,x}, 10 bits): S0 accept cycle issues sync RAM read; S1 (next cycle)
//    RAM data valid, compare, on pass write z to RAM; out_* registered from S1 -> out_valid
//    exactly 2 cycles after acceptance. Full throughput: 1 pixel/cycle.
//  - RAM is read-before-write; hazard: S1 compares against forwarded z when S1 address equals
//    address of previous cycle's passing write (registered last-write addr/z/valid). Write in
//    the same cycle as a colliding read is also forwarded by the same rule next cycle.
//    Back-to-back same-address pixels therefore see the latest committed depth.
//  - Failing pixels: no RAM write, out_pass=0, coordinates/z still echoed.
//  - tile_done asserted with the out_valid beat whose out_last=1; no state change on it.
//  - Unsigned compare; all-ones stored depth fails only z==all-ones under LESS.
// STRUCTURE
//  - Package z_pkg: Z_W, TILE_LOG2, ZFAR = '1, typedef z_t [Z_W-1:0], coord_t [TILE_LOG2-1:0],
//    tile_addr_t [2*TILE_LOG2-1:0], enum dt_state_e {CLEAR, RUN, DRAIN}.
//  - Sub-module z_tile_ram: 1R1W simple dual-port, sync read, 1-cycle latency, read-before-write.
//  - Top: FSM + clear counter, S0/S1 registers, forwarding register, compare, output regs.
// TESTING
//  1 rst 1 cycle -> clear_busy=1, in_ready=0 for exactly 1024 cycles, then in_ready=1.
//  2 (3,4,z=100) -> 2 cycles later out_valid, out_pass=1; then (3,4,200) -> pass=0; (3,4,50) -> pass=1.
//  3 back-to-back same addr (7,7): z=500,400,450,300 consecutive cycles -> pass=1,1,0,1 (forwarding).
//  4 LEQUAL=0: (1,1,80) then (1,1,80) -> pass=1,0; LEQUAL=1 -> pass=1,1.
//  5 full 1024-pixel raster, z=addr, in_last on final -> all pass, one tile_done 2 cycles after last.
//  6 clear_start with in_valid mid-stream -> that pixel not accepted, 2 in-flight outputs emerge,
//    then 1024-cycle clear; earlier-written (3,4) then passes at z=ZFAR-1.
//  7 rst during CLEAR at cnt=500 -> clear restarts, 1024 full cycles before in_ready.

Source files
------------

// File: rtl/z_depth_test_pkg.sv
// Shared types and constants for the tile depth-test stage.
package z_pkg;

    localparam int Z_W       = 27;
    localparam int TILE_LOG2 = 5;
    localparam int ADDR_W    = 2 * TILE_LOG2;

    typedef logic [Z_W-1:0]       z_t;
    typedef logic [TILE_LOG2-1:0] coord_t;
    typedef logic [ADDR_W-1:0]    tile_addr_t;

    // Far-plane depth used to initialise the tile buffer.
    localparam z_t         ZFAR      = {Z_W{1'b1}};
    localparam tile_addr_t LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dt_state_e;

    // Unsigned depth comparison. lequal selects <= instead of <.
    function automatic logic depth_pass(input z_t z, input z_t stored, input logic lequal);
        logic res;
        if (lequal) begin
            res = (z <= stored);
        end else begin
            res = (z < stored);
        end
        return res;
    endfunction

endpackage

// File: rtl/z_depth_test_tile_ram.sv
// Tile depth buffer: one read port, one write port, registered read.
// A read and a write to the same address in one cycle return the old data.
module z_tile_ram
    import z_pkg::*;
(
    input  logic       clk,
    input  logic       re,
    input  tile_addr_t raddr,
    output z_t         rdata,
    input  logic       we,
    input  tile_addr_t waddr,
    input  z_t         wdata
);

    z_t mem [0:(1<<ADDR_W)-1];

    // Write port and registered read port (old data on collision).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/z_depth_test.sv
// Depth-test stage for one 32x32 tile: read stored depth on accept, compare
// one cycle later (with forwarding of the previous cycle's write), write back
// passing depth, and register the result. Also owns clearing of the buffer.
module z_depth_test
    import z_pkg::*;
#(
    parameter logic LEQUAL = 1'b0
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_start,
    output logic                 clear_busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TILE_LOG2-1:0] in_x,
    input  logic [TILE_LOG2-1:0] in_y,
    input  logic [Z_W-1:0]       in_z,
    input  logic                 in_last,
    output logic                 out_valid,
    output logic [TILE_LOG2-1:0] out_x,
    output logic [TILE_LOG2-1:0] out_y,
    output logic [Z_W-1:0]       out_z,
    output logic                 out_pass,
    output logic                 out_last,
    output logic                 tile_done
);

    dt_state_e  state_r, state_s;
    tile_addr_t clr_cnt_r;
    logic       accept_s;

    logic       s1_valid_r;
    coord_t     s1_x_r, s1_y_r;
    z_t         s1_z_r;
    logic       s1_last_r;

    logic       fwd_valid_r;
    tile_addr_t fwd_addr_r;
    z_t         fwd_z_r;

    tile_addr_t s1_addr_s;
    z_t         rd_data_s, cmp_z_s;
    logic       s1_pass_s;
    logic       ram_we_s;
    tile_addr_t ram_waddr_s;
    z_t         ram_wdata_s;

    // Next state and handshake outputs; a clear request wins over a pixel.
    always_comb begin
        state_s    = state_r;
        in_ready   = 1'b0;
        clear_busy = 1'b1;
        case (state_r)
            CLEAR: begin
                if (clr_cnt_r == LAST_ADDR) begin
                    state_s = RUN;
                end else begin
                    state_s = CLEAR;
                end
            end
            RUN: begin
                in_ready   = !clear_start;
                clear_busy = 1'b0;
                if (clear_start) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                // Only S1 can still write the buffer; wait for it to empty.
                if (!s1_valid_r) begin
                    state_s = CLEAR;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = CLEAR;
            end
        endcase
    end

    assign accept_s = in_valid && in_ready;

    // State register and clear address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= CLEAR;
            clr_cnt_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == CLEAR) begin
                clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                clr_cnt_r <= {ADDR_W{1'b0}};
            end
        end
    end

    // Compare against the previous cycle's write when addresses collide,
    // since the RAM read for this pixel was issued before that write landed.
    always_comb begin
        s1_addr_s = {s1_y_r, s1_x_r};
        if (fwd_valid_r && (fwd_addr_r == s1_addr_s)) begin
            cmp_z_s = fwd_z_r;
        end else begin
            cmp_z_s = rd_data_s;
        end
        s1_pass_s = s1_valid_r && depth_pass(s1_z_r, cmp_z_s, LEQUAL);
    end

    // RAM write source: far-plane fill while clearing, otherwise passing pixels.
    always_comb begin
        if (state_r == CLEAR) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_cnt_r;
            ram_wdata_s = ZFAR;
        end else begin
            ram_we_s    = s1_pass_s;
            ram_waddr_s = s1_addr_s;
            ram_wdata_s = s1_z_r;
        end
    end

    z_tile_ram u_ram (
        .clk   (clk),
        .re    (accept_s),
        .raddr ({in_y, in_x}),
        .rdata (rd_data_s),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s)
    );

    // S1 pipeline register: pixel whose stored depth arrives this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= {TILE_LOG2{1'b0}};
            s1_y_r     <= {TILE_LOG2{1'b0}};
            s1_z_r     <= {Z_W{1'b0}};
            s1_last_r  <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_x_r    <= in_x;
                s1_y_r    <= in_y;
                s1_z_r    <= in_z;
                s1_last_r <= in_last;
            end
        end
    end

    // Forwarding register: the write committed in the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_r <= 1'b0;
            fwd_addr_r  <= {ADDR_W{1'b0}};
            fwd_z_r     <= {Z_W{1'b0}};
        end else begin
            fwd_valid_r <= s1_pass_s;
            fwd_addr_r  <= s1_addr_s;
            fwd_z_r     <= s1_z_r;
        end
    end

    // Registered result towards the pixel writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= {TILE_LOG2{1'b0}};
            out_y     <= {TILE_LOG2{1'b0}};
            out_z     <= {Z_W{1'b0}};
            out_pass  <= 1'b0;
            out_last  <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            out_valid <= s1_valid_r;
            out_pass  <= s1_pass_s;
            out_last  <= s1_valid_r && s1_last_r;
            tile_done <= s1_valid_r && s1_last_r;
            if (s1_valid_r) begin
                out_x <= s1_x_r;
                out_y <= s1_y_r;
                out_z <= s1_z_r;
            end
        end
    end

endmodule

// File: tb/tb_z_depth_test.sv
// Scoreboard bench for z_depth_test: a reference depth buffer predicts each
// accepted pixel's result for both compare modes; outputs are popped and
// compared as they appear.
module tb_z_depth_test;
    import z_pkg::*;

    logic   clk = 1'b0;
    logic   rst, clear_start, in_valid, in_last;
    coord_t in_x, in_y;
    z_t     in_z;

    logic   clear_busy, in_ready, out_valid, out_pass, out_last, tile_done;
    coord_t out_x, out_y;
    z_t     out_z;

    logic   b_clear_busy, b_in_ready, b_out_valid, b_out_pass, b_out_last, b_tile_done;
    coord_t b_out_x, b_out_y;
    z_t     b_out_z;

    always #5 clk = ~clk;

    z_depth_test #(.LEQUAL(1'b0)) dut (
        .clk(clk), .rst(rst), .clear_start(clear_start), .clear_busy(clear_busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_z(in_z), .in_last(in_last), .out_valid(out_valid), .out_x(out_x),
        .out_y(out_y), .out_z(out_z), .out_pass(out_pass), .out_last(out_last),
        .tile_done(tile_done)
    );

    z_depth_test #(.LEQUAL(1'b1)) dut_le (
        .clk(clk), .rst(rst), .clear_start(clear_start), .clear_busy(b_clear_busy),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_x(in_x), .in_y(in_y),
        .in_z(in_z), .in_last(in_last), .out_valid(b_out_valid), .out_x(b_out_x),
        .out_y(b_out_y), .out_z(b_out_z), .out_pass(b_out_pass), .out_last(b_out_last),
        .tile_done(b_tile_done)
    );

    typedef struct {
        coord_t x;
        coord_t y;
        z_t     z;
        logic   pass_lt;
        logic   pass_le;
        logic   last;
        int     cyc;
    } exp_t;

    exp_t sb[$];
    z_t   model_depth [0:1023];
    logic pass_log[$];
    logic pass_log_le[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   tile_done_cnt = 0;
    int   out_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) begin
            model_depth[i] = ZFAR;
        end
    endtask

    // Cycle counter for latency measurement.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard: pop and compare outputs, predict and push accepted pixels.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid) begin
                    out_cnt++;
                    if (sb.size() == 0) begin
                        check_val("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_val("out_x", 32'(out_x), 32'(e.x));
                        check_val("out_y", 32'(out_y), 32'(e.y));
                        check_val("out_z", 32'(out_z), 32'(e.z));
                        check_val("out_pass", 32'(out_pass), 32'(e.pass_lt));
                        check_val("out_last", 32'(out_last), 32'(e.last));
                        check_val("tile_done", 32'(tile_done), 32'(e.last));
                        check_val("latency", 32'(cyc - e.cyc), 32'd2);
                        check_val("le_valid", 32'(b_out_valid), 32'd1);
                        check_val("le_pass", 32'(b_out_pass), 32'(e.pass_le));
                        pass_log.push_back(out_pass);
                        pass_log_le.push_back(b_out_pass);
                    end
                end
                if (tile_done) begin
                    tile_done_cnt++;
                end
                if (in_valid && in_ready) begin
                    a         = int'({in_y, in_x});
                    e.x       = in_x;
                    e.y       = in_y;
                    e.z       = in_z;
                    e.last    = in_last;
                    e.cyc     = cyc;
                    e.pass_lt = (in_z <  model_depth[a]);
                    e.pass_le = (in_z <= model_depth[a]);
                    if (e.pass_lt) begin
                        model_depth[a] = in_z;
                    end
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic drive(input int x, input int y, input z_t z, input logic last);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x     = coord_t'(x);
        in_y     = coord_t'(y);
        in_z     = z;
        in_last  = last;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        check_val(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        clear_start = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_clear();
    endtask

    // Count cycles with clear_busy high and in_ready low until in_ready rises.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                break;
            end
            if (clear_busy) begin
                n++;
            end
        end
    endtask

    initial begin
        int n;
        int passes;
        rst         = 1'b1;
        clear_start = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_x        = '0;
        in_y        = '0;
        in_z        = '0;
        model_clear();

        // 1: reset state and clear length
        do_reset();
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_clear_busy", 32'(clear_busy), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_pass", 32'(out_pass), 32'd0);
        check_val("rst_out_last", 32'(out_last), 32'd0);
        check_val("rst_tile_done", 32'(tile_done), 32'd0);
        check_val("rst_out_xyz", 32'({out_x, out_y}) | 32'(out_z), 32'd0);
        count_busy(n);
        check_val("clear_len", 32'(n), 32'd1024);
        check_val("ready_after_clear", 32'(in_ready), 32'd1);

        // 2: single pixels at (3,4)
        pass_log.delete();
        drive(3, 4, z_t'(100), 1'b0); idle(); wait_drain("t2a_drain");
        drive(3, 4, z_t'(200), 1'b0); idle(); wait_drain("t2b_drain");
        drive(3, 4, z_t'(50), 1'b0);  idle(); wait_drain("t2c_drain");
        check_val("t2_count", 32'(pass_log.size()), 32'd3);
        check_val("t2_pass0", 32'(pass_log[0]), 32'd1);
        check_val("t2_pass1", 32'(pass_log[1]), 32'd0);
        check_val("t2_pass2", 32'(pass_log[2]), 32'd1);

        // 3: back-to-back same address needs forwarding
        pass_log.delete();
        drive(7, 7, z_t'(500), 1'b0);
        drive(7, 7, z_t'(400), 1'b0);
        drive(7, 7, z_t'(450), 1'b0);
        drive(7, 7, z_t'(300), 1'b0);
        idle(); wait_drain("t3_drain");
        check_val("t3_count", 32'(pass_log.size()), 32'd4);
        check_val("t3_pass0", 32'(pass_log[0]), 32'd1);
        check_val("t3_pass1", 32'(pass_log[1]), 32'd1);
        check_val("t3_pass2", 32'(pass_log[2]), 32'd0);
        check_val("t3_pass3", 32'(pass_log[3]), 32'd1);

        // 4: equal depth under both compare modes
        pass_log.delete();
        pass_log_le.delete();
        drive(1, 1, z_t'(80), 1'b0);
        drive(1, 1, z_t'(80), 1'b0);
        idle(); wait_drain("t4_drain");
        check_val("t4_lt_pass0", 32'(pass_log[0]), 32'd1);
        check_val("t4_lt_pass1", 32'(pass_log[1]), 32'd0);
        check_val("t4_le_pass0", 32'(pass_log_le[0]), 32'd1);
        check_val("t4_le_pass1", 32'(pass_log_le[1]), 32'd1);

        // 6: clear request mid-stream
        out_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(i, 10, z_t'(1000 + i), 1'b0);
        end
        @(posedge clk);
        #1;
        clear_start = 1'b1;
        in_valid    = 1'b1;
        in_x        = coord_t'(4);
        in_y        = coord_t'(10);
        in_z        = z_t'(1004);
        @(negedge clk);
        check_val("t6_clear_wins", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        in_valid    = 1'b0;
        model_clear();
        count_busy(n);
        check_val("t6_clear_len", 32'((n >= 1024) && (n <= 1026)), 32'd1);
        check_val("t6_outputs", 32'(out_cnt), 32'd4);
        check_val("t6_sb_empty", 32'(sb.size()), 32'd0);
        pass_log.delete();
        drive(3, 4, ZFAR - z_t'(1), 1'b0); idle(); wait_drain("t6_drain");
        check_val("t6_far_pass", 32'(pass_log[0]), 32'd1);

        // 5: full raster, z = address
        pass_log.delete();
        tile_done_cnt = 0;
        for (int a = 0; a < 1024; a++) begin
            drive(a % 32, a / 32, z_t'(a), (a == 1023));
        end
        idle(); wait_drain("t5_drain");
        passes = 0;
        foreach (pass_log[i]) begin
            if (pass_log[i]) begin
                passes++;
            end
        end
        check_val("t5_passes", 32'(passes), 32'd1024);
        check_val("t5_tile_done", 32'(tile_done_cnt), 32'd1);

        // 7: reset in the middle of a clear restarts it
        do_reset();
        repeat (500) @(negedge clk);
        check_val("t7_busy_mid", 32'(clear_busy), 32'd1);
        do_reset();
        count_busy(n);
        check_val("t7_clear_len", 32'(n), 32'd1024);
        pass_log.delete();
        drive(0, 0, z_t'(5), 1'b0); idle(); wait_drain("t7_drain");
        check_val("t7_pass", 32'(pass_log[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
